// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;
  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            err;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer; head is driven straight from storage.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  entry_t        i_push_data,
  input  logic          i_pop,
  output entry_t        o_head,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop_ok;
  logic          w_push_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle frees the slot, so push at full is accepted.
  assign w_pop_ok  = i_pop && (r_count != '0);
  assign w_push_ok = i_push && ((r_count != CW'(DEPTH)) || w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding req/gnt/rvalid word read, results buffered with their PC.
module instr_fetch_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid_i,
  input  logic            redirect_i,
  output logic            fetch_stall_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            imem_err_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic            instr_err_o
);
  import riscv_pkg::*;

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_mis_pc;
  logic            r_mis_pending;
  logic            r_discard;

  logic [CW-1:0]   w_count;
  logic [CW+1:0]   w_cap;
  logic [CW+1:0]   w_used;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;
  logic            w_head_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_resp;
  logic            w_aligned;
  logic            w_block;
  logic            w_slot;
  logic            w_accept;

  assign w_pop     = w_head_valid && instr_ready_i;
  assign w_resp    = (r_state == F_WAIT) && imem_rvalid_i;
  assign w_aligned = (pc_i[1:0] == 2'b00);

  // A misaligned entry waiting to be pushed also holds a slot.
  assign w_cap  = (CW+2)'(BUF_DEPTH) + (CW+2)'(w_pop);
  assign w_used = (CW+2)'(w_count) + (CW+2)'(r_state != F_IDLE) + (CW+2)'(r_mis_pending);
  assign w_slot = (w_cap > w_used);

  assign w_block  = r_discard ||
                    (redirect_i && ((r_state == F_REQ) || ((r_state == F_WAIT) && !imem_rvalid_i)));
  assign w_accept = pc_valid_i && w_slot && !w_block &&
                    ((r_state == F_IDLE) || (w_resp && w_aligned));

  assign w_push = (w_resp && !r_discard && !redirect_i) || r_mis_pending;

  always_comb begin
    w_push_data = '0;
    if (r_mis_pending) begin
      w_push_data.pc    = r_mis_pc;
      w_push_data.instr = NOP_INSTR;
      w_push_data.err   = 1'b1;
    end else begin
      w_push_data.pc    = r_addr;
      w_push_data.instr = imem_err_i ? NOP_INSTR : imem_rdata_i;
      w_push_data.err   = imem_err_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= F_IDLE;
      r_addr        <= '0;
      r_mis_pc      <= '0;
      r_mis_pending <= 1'b0;
      r_discard     <= 1'b0;
    end else begin
      r_mis_pending <= w_accept && !w_aligned;
      if (w_accept) begin
        if (w_aligned) r_addr   <= pc_i;
        else           r_mis_pc <= pc_i;
      end
      case (r_state)
        F_IDLE:  if (w_accept && w_aligned) r_state <= F_REQ;
        F_REQ:   if (imem_gnt_i) r_state <= F_WAIT;
        F_WAIT:  if (imem_rvalid_i) r_state <= w_accept ? F_REQ : F_IDLE;
        default: r_state <= F_IDLE;
      endcase
      if (w_resp)                               r_discard <= 1'b0;
      else if (redirect_i && r_state != F_IDLE) r_discard <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH   (BUF_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_flush     (redirect_i),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_valid     (w_head_valid),
    .o_count     (w_count)
  );

  assign fetch_stall_o = pc_valid_i && !w_accept;
  assign imem_req_o    = (r_state == F_REQ);
  assign imem_addr_o   = {r_addr[XLEN-1:2], 2'b00};
  assign instr_valid_o = w_head_valid;
  assign instr_o       = w_head_valid ? w_head.instr : NOP_INSTR;
  assign instr_pc_o    = w_head_valid ? w_head.pc : '0;
  assign instr_err_o   = w_head_valid && w_head.err;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model, PC driver, scoreboarded output monitor.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ERR_ADR = 32'h0000_0030;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        redirect_i;
  logic        fetch_stall_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_err_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        instr_err_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  vec_t        expq[$];
  vec_t        vecs[4];

  int unsigned gnt_hold     = 0;
  int unsigned rvalid_delay = 0;
  logic        resp_pend    = 1'b0;
  int unsigned resp_wait    = 0;
  logic [31:0] resp_addr    = '0;

  instr_fetch_unit #(
    .XLEN      (32),
    .BUF_DEPTH (2),
    .NOP_INSTR (NOP)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .redirect_i    (redirect_i),
    .fetch_stall_o (fetch_stall_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .imem_err_i    (imem_err_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_err_o   (instr_err_o)
  );

  initial forever #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory: gnt after gnt_hold cycles of req, rvalid rvalid_delay+1 cycles after gnt.
  initial begin
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    imem_err_i    = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      imem_err_i    = 1'b0;
      imem_gnt_i    = 1'b0;
      if (RST) begin
        resp_pend = 1'b0;
        continue;
      end
      if (resp_pend) begin
        if (resp_wait == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(resp_addr);
          imem_err_i    = (resp_addr == ERR_ADR);
          resp_pend     = 1'b0;
        end else begin
          resp_wait--;
        end
      end
      if (imem_req_o && !resp_pend) begin
        if (gnt_hold > 0) begin
          gnt_hold--;
        end else begin
          imem_gnt_i = 1'b1;
          resp_pend  = 1'b1;
          resp_addr  = imem_addr_o;
          resp_wait  = rvalid_delay;
        end
      end
    end
  end

  // Output monitor: every popped head is compared against the scoreboard.
  initial begin
    vec_t e;
    forever begin
      @(negedge CLK);
      if (!RST && instr_valid_o && instr_ready_i) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr: got pc %h, expected no output", instr_pc_o);
        end else begin
          e = expq.pop_front();
          chk("instr_pc", instr_pc_o, e.pc);
          chk("instr", instr_o, e.instr);
          chk("instr_err", 32'(instr_err_o), 32'(e.err));
        end
      end
    end
  end

  task automatic drive_pc(input logic [31:0] pc, input logic [31:0] ei, input logic ee);
    int unsigned n = 0;
    logic ok = 1'b1;
    pc_i       = pc;
    pc_valid_i = 1'b1;
    forever begin
      @(negedge CLK);
      if (!fetch_stall_o) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: pc %h still stalled, expected accept", pc);
        ok = 1'b0;
        break;
      end
    end
    if (ok) expq.push_back('{pc: pc, instr: ei, err: ee});
    @(posedge CLK);
    #2;
    pc_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (expq.size() != 0 || instr_valid_o || imem_req_o || resp_pend) begin
      @(negedge CLK);
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout: %0d entries left, expected 0", expq.size());
        break;
      end
    end
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST           = 1'b1;
    pc_i          = '0;
    pc_valid_i    = 1'b0;
    redirect_i    = 1'b0;
    instr_ready_i = 1'b1;

    vecs[0] = '{pc: 32'h4,  instr: mem_word(32'h4), err: 1'b0};
    vecs[1] = '{pc: 32'h8,  instr: mem_word(32'h8), err: 1'b0};
    vecs[2] = '{pc: ERR_ADR, instr: NOP,            err: 1'b1};
    vecs[3] = '{pc: 32'hC,  instr: mem_word(32'hC), err: 1'b0};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", instr_pc_o, 32'd0);
    chk("rst_err", 32'(instr_err_o), 32'd0);
    chk("rst_stall", 32'(fetch_stall_o), 32'd0);
    @(posedge CLK);
    #2;
    RST = 1'b0;

    // Latency: accepted in N, valid in N+3.
    drive_pc(32'h0, mem_word(32'h0), 1'b0);
    @(negedge CLK) chk("lat_n1_valid", 32'(instr_valid_o), 32'd0);
    chk("lat_n1_req", 32'(imem_req_o), 32'd1);
    @(negedge CLK) chk("lat_n2_valid", 32'(instr_valid_o), 32'd0);
    @(negedge CLK) chk("lat_n3_valid", 32'(instr_valid_o), 32'd1);
    @(posedge CLK);
    #2;

    for (int i = 0; i < 4; i++) drive_pc(vecs[i].pc, vecs[i].instr, vecs[i].err);
    wait_drain();

    // Grant held off for 3 cycles.
    gnt_hold = 3;
    drive_pc(32'h10, mem_word(32'h10), 1'b0);
    pc_i       = 32'h14;
    pc_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("gnt_wait_req", 32'(imem_req_o), 32'd1);
      chk("gnt_wait_addr", imem_addr_o, 32'h10);
      chk("gnt_wait_stall", 32'(fetch_stall_o), 32'd1);
    end
    drive_pc(32'h14, mem_word(32'h14), 1'b0);
    wait_drain();

    // Misaligned PC: no memory request, NOP with error.
    drive_pc(32'h22, NOP, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK) chk("misaligned_no_req", 32'(imem_req_o), 32'd0);
    end
    @(posedge CLK);
    #2;
    wait_drain();

    // Consumer stalled: buffer fills, third PC held.
    instr_ready_i = 1'b0;
    drive_pc(32'h40, mem_word(32'h40), 1'b0);
    drive_pc(32'h44, mem_word(32'h44), 1'b0);
    pc_i       = 32'h48;
    pc_valid_i = 1'b1;
    repeat (3) @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("full_stall", 32'(fetch_stall_o), 32'd1);
      chk("full_no_req", 32'(imem_req_o), 32'd0);
      chk("full_head_pc", instr_pc_o, 32'h40);
    end
    @(posedge CLK);
    #2;
    instr_ready_i = 1'b1;
    drive_pc(32'h48, mem_word(32'h48), 1'b0);
    wait_drain();

    // Redirect while waiting on 0x20.
    rvalid_delay = 3;
    drive_pc(32'h20, mem_word(32'h20), 1'b0);
    @(posedge CLK);
    #2;
    redirect_i = 1'b1;
    @(posedge CLK);
    #2;
    redirect_i = 1'b0;
    expq.delete();
    @(negedge CLK) chk("redirect_empty", 32'(instr_valid_o), 32'd0);
    @(posedge CLK);
    #2;
    rvalid_delay = 0;
    drive_pc(32'h100, mem_word(32'h100), 1'b0);
    wait_drain();

    // Reset while in WAIT.
    rvalid_delay = 2;
    drive_pc(32'h50, mem_word(32'h50), 1'b0);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #2;
    RST = 1'b0;
    expq.delete();
    rvalid_delay = 0;
    @(negedge CLK);
    chk("wait_rst_req", 32'(imem_req_o), 32'd0);
    chk("wait_rst_addr", imem_addr_o, 32'd0);
    chk("wait_rst_valid", 32'(instr_valid_o), 32'd0);
    chk("wait_rst_instr", instr_o, NOP);
    chk("wait_rst_pc", instr_pc_o, 32'd0);
    chk("wait_rst_err", 32'(instr_err_o), 32'd0);
    @(posedge CLK);
    #2;
    drive_pc(32'h54, mem_word(32'h54), 1'b0);
    wait_drain();

    chk("scoreboard_empty", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
